// File: rtl/instr_mem_loadable.sv
// Run-time loadable instruction memory: a word-stream loader fills the array after
// reset, then a request/valid fetch port with 1- or 2-cycle latency serves the core.
module instr_mem_loadable #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 32,
    parameter int                ADDR_W   = 32,
    parameter int                RD_LAT   = 1,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load_valid,
    input  logic [DATA_W-1:0]        load_data,
    input  logic                     load_done,
    output logic                     load_full,
    output logic [$clog2(DEPTH):0]   load_count,
    output logic                     core_ready,
    input  logic                     fetch_req,
    input  logic [ADDR_W-1:0]        fetch_addr,
    output logic                     fetch_valid,
    output logic [DATA_W-1:0]        fetch_instr,
    output logic                     fetch_fault
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    typedef enum logic {
        ST_LOAD,
        ST_RUN
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               full_q, full_d;
    logic               wr_en;
    logic [DATA_W-1:0]  mem [DEPTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        wr_en   = 1'b0;
        if (state_q == ST_LOAD) begin
            if (load_valid && !full_q) begin
                wr_en   = 1'b1;
                count_d = count_q + 1'b1;
            end
            if (load_done) begin
                state_d = ST_RUN;
            end
        end
    end

    assign full_d = (count_d == CNT_W'(DEPTH));

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            full_q  <= full_d;
        end
    end

    // NOTE: the array has no reset; the program image must survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[count_q[IDX_W-1:0]] <= load_data;
        end
    end

    assign load_count = count_q;
    assign load_full  = full_q;
    assign core_ready = (state_q == ST_RUN);

    // Range check uses the whole address so high bits never alias into the array.
    logic [ADDR_W-1:0] word_idx;
    logic              addr_fault;
    logic              fetch_accept;

    assign word_idx     = fetch_addr >> 2;
    assign addr_fault   = (fetch_addr[1:0] != 2'b00) || (word_idx >= ADDR_W'(DEPTH));
    assign fetch_accept = fetch_req && (state_q == ST_RUN);

    logic              s1_valid_q;
    logic              s1_fault_q;
    logic [DATA_W-1:0] s1_data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_fault_q <= 1'b0;
            s1_data_q  <= '0;
        end else begin
            s1_valid_q <= fetch_accept;
            if (fetch_accept) begin
                s1_fault_q <= addr_fault;
                s1_data_q  <= addr_fault ? NOP_WORD : mem[word_idx[IDX_W-1:0]];
            end
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              s2_valid_q;
        logic              s2_fault_q;
        logic [DATA_W-1:0] s2_data_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                s2_valid_q <= 1'b0;
                s2_fault_q <= 1'b0;
                s2_data_q  <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_fault_q <= s1_fault_q;
                    s2_data_q  <= s1_data_q;
                end
            end
        end

        assign fetch_valid = s2_valid_q;
        assign fetch_instr = s2_data_q;
        assign fetch_fault = s2_fault_q;
    end else begin : g_lat1
        assign fetch_valid = s1_valid_q;
        assign fetch_instr = s1_data_q;
        assign fetch_fault = s1_fault_q;
    end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Directed bench: one RD_LAT=1 and one RD_LAT=2 instance share stimulus; the
// expected words are written out by hand below.
module tb_instr_mem_loadable;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;

    logic              full1, full2, ready1, ready2;
    logic [CNT_W-1:0]  cnt1, cnt2;
    logic              fv1, fv2, ff1, ff2;
    logic [DATA_W-1:0] fi1, fi2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    instr_mem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) u_lat1 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_done  (load_done),
        .load_full  (full1),
        .load_count (cnt1),
        .core_ready (ready1),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fv1),
        .fetch_instr(fi1),
        .fetch_fault(ff1)
    );

    instr_mem_loadable #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) u_lat2 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_done  (load_done),
        .load_full  (full2),
        .load_count (cnt2),
        .core_ready (ready2),
        .fetch_req  (fetch_req),
        .fetch_addr (fetch_addr),
        .fetch_valid(fv2),
        .fetch_instr(fi2),
        .fetch_fault(ff2)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        load_valid = 1'b0;
        load_done  = 1'b0;
        fetch_req  = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    // One isolated fetch: RD_LAT=1 answers after the first edge, RD_LAT=2 after the second.
    task automatic do_fetch(input string tag, input logic [31:0] addr,
                            input logic [31:0] exp_instr, input logic exp_fault);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        step();
        fetch_req = 1'b0;
        check({tag, " l1 valid"}, 32'(fv1), 32'd1);
        check({tag, " l1 instr"}, fi1, exp_instr);
        check({tag, " l1 fault"}, 32'(ff1), 32'(exp_fault));
        check({tag, " l2 early"}, 32'(fv2), 32'd0);
        step();
        check({tag, " l1 one-shot"}, 32'(fv1), 32'd0);
        check({tag, " l1 hold"}, fi1, exp_instr);
        check({tag, " l2 valid"}, 32'(fv2), 32'd1);
        check({tag, " l2 instr"}, fi2, exp_instr);
        check({tag, " l2 fault"}, 32'(ff2), 32'(exp_fault));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] prog [3];
        logic [31:0] b2b [8];
        prog[0] = 32'h3c01_0000;
        prog[1] = 32'h3424_0050;
        prog[2] = 32'h2005_0004;
        b2b[0]  = prog[0];
        b2b[1]  = prog[1];
        b2b[2]  = prog[2];
        for (int i = 3; i < 8; i++) b2b[i] = 32'hc0de_0000 + 32'(i);

        load_data  = '0;
        fetch_addr = '0;
        do_reset();

        // Reset state.
        check("rst count1", 32'(cnt1), 32'd0);
        check("rst count2", 32'(cnt2), 32'd0);
        check("rst full1", 32'(full1), 32'd0);
        check("rst ready1", 32'(ready1), 32'd0);
        check("rst ready2", 32'(ready2), 32'd0);
        check("rst valid1", 32'(fv1), 32'd0);
        check("rst valid2", 32'(fv2), 32'd0);
        check("rst instr1", fi1, 32'd0);
        check("rst instr2", fi2, 32'd0);
        check("rst fault1", 32'(ff1), 32'd0);
        check("rst fault2", 32'(ff2), 32'd0);

        // Overfill: DEPTH+2 words, the last two must be dropped.
        for (int i = 0; i < DEPTH + 2; i++) begin
            load_valid = 1'b1;
            load_data  = 32'hc0de_0000 + 32'(i);
            step();
            check("fill count", 32'(cnt1), (i + 1 < DEPTH) ? 32'(i + 1) : 32'(DEPTH));
            check("fill full", 32'(full1), (i + 1 >= DEPTH) ? 32'd1 : 32'd0);
        end
        check("fill count2", 32'(cnt2), 32'(DEPTH));
        check("fill ready low", 32'(ready1), 32'd0);
        load_valid = 1'b0;
        load_done  = 1'b1;
        step();
        load_done = 1'b0;
        check("fill ready1", 32'(ready1), 32'd1);
        check("fill ready2", 32'(ready2), 32'd1);
        do_fetch("fill last", 32'((DEPTH - 1) * 4), 32'hc0de_001f, 1'b0);
        do_fetch("fill nowrap", 32'h0, 32'hc0de_0000, 1'b0);

        // Three-word program; fetch requests during LOAD must be ignored.
        do_reset();
        check("ld2 count", 32'(cnt1), 32'd0);
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            fetch_req  = 1'b1;
            fetch_addr = 32'h0;
            step();
            check("ld2 no fetch1", 32'(fv1), 32'd0);
            check("ld2 no fetch2", 32'(fv2), 32'd0);
        end
        fetch_req  = 1'b0;
        load_valid = 1'b0;
        check("ld2 count3", 32'(cnt1), 32'd3);
        check("ld2 ready pre", 32'(ready1), 32'd0);
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        check("ld2 ready1", 32'(ready1), 32'd1);
        check("ld2 ready2", 32'(ready2), 32'd1);
        check("ld2 count done", 32'(cnt1), 32'd3);
        do_fetch("f0", 32'h0, prog[0], 1'b0);
        do_fetch("f4", 32'h4, prog[1], 1'b0);
        do_fetch("f8", 32'h8, prog[2], 1'b0);

        // Faults: misaligned, just past the end, and a high-bit alias of word 1.
        do_fetch("mis06", 32'h6, 32'h0, 1'b1);
        do_fetch("oob80", 32'(DEPTH * 4), 32'h0, 1'b1);
        do_fetch("alias", 32'h1000_0004, 32'h0, 1'b1);
        do_fetch("after flt", 32'h4, prog[1], 1'b0);

        // Back-to-back fetches 0..0x1c, no bubbles on either latency.
        for (int t = 0; t < 9; t++) begin
            fetch_req  = (t < 8);
            fetch_addr = 32'(t * 4);
            step();
            if (t < 8) begin
                check("b2b l1 valid", 32'(fv1), 32'd1);
                check("b2b l1 instr", fi1, b2b[t]);
            end else begin
                check("b2b l1 end", 32'(fv1), 32'd0);
            end
            if (t >= 1) begin
                check("b2b l2 valid", 32'(fv2), 32'd1);
                check("b2b l2 instr", fi2, b2b[t-1]);
            end else begin
                check("b2b l2 first", 32'(fv2), 32'd0);
            end
        end
        fetch_req = 1'b0;
        step();
        check("b2b l2 end", 32'(fv2), 32'd0);

        // Simultaneous load_valid + load_done, then writes in RUN are ignored.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = prog[i];
            step();
        end
        load_data = 32'h0c00_0018;
        load_done = 1'b1;
        step();
        check("sim count", 32'(cnt1), 32'd4);
        check("sim ready", 32'(ready1), 32'd1);
        load_data = 32'hdead_beef;
        step();
        load_valid = 1'b0;
        load_done  = 1'b0;
        check("run count", 32'(cnt1), 32'd4);
        do_fetch("sim w3", 32'hc, 32'h0c00_0018, 1'b0);
        do_fetch("run w4", 32'h10, 32'hc0de_0004, 1'b0);

        // Reset with fetches in flight, then a one-word reload.
        fetch_req  = 1'b1;
        fetch_addr = 32'h0;
        step();
        fetch_addr = 32'h4;
        step();
        fetch_req = 1'b0;
        reset     = 1'b1;
        step();
        check("mid valid1", 32'(fv1), 32'd0);
        check("mid valid2", 32'(fv2), 32'd0);
        check("mid ready", 32'(ready1), 32'd0);
        check("mid count", 32'(cnt1), 32'd0);
        check("mid instr2", fi2, 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post valid1", 32'(fv1), 32'd0);
            check("post valid2", 32'(fv2), 32'd0);
            check("post ready", 32'(ready2), 32'd0);
        end
        load_valid = 1'b1;
        load_data  = 32'haaaa_5555;
        step();
        load_valid = 1'b0;
        load_done  = 1'b1;
        step();
        load_done = 1'b0;
        check("rl count", 32'(cnt1), 32'd1);
        check("rl ready", 32'(ready1), 32'd1);
        do_fetch("rl w0", 32'h0, 32'haaaa_5555, 1'b0);
        do_fetch("rl w1", 32'h4, prog[1], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_mem_loadable.md
Name: instr_mem_loadable

Overview:
- Parametrised, synchronous-read instruction memory for the next-generation CPU.
- Replaces the fixed, initial-block-filled program store with a run-time loader: a word-stream write port fills memory after reset, then the block releases the core.
- Fetches use a request/valid pipeline with configurable read latency.
- Misaligned and out-of-range fetches raise a fault and return a NOP instead of undefined data.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 32, number of instruction words; power of two, 2..4096.
- ADDR_W, 32, width of the byte address from the PC.
- RD_LAT, 1, fetch latency in cycles; legal values are 1 or 2.
- NOP_WORD, 32'h00000000, word returned on a faulted fetch (sll $0,$0,0).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- load_valid  in  1  load word present this cycle.
- load_data  in  DATA_W  word to write at the load pointer.
- load_done  in  1  end-of-program strobe from the loader.
- load_full  out  1  pointer has reached DEPTH; further load words are dropped.
- load_count  out  clog2(DEPTH)+1  number of words written since reset.
- core_ready  out  1  high in RUN; the core holds its PC while low.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  byte address, normally the PC.
- fetch_valid  out  1  fetch_instr/fetch_fault valid this cycle.
- fetch_instr  out  DATA_W  fetched instruction.
- fetch_fault  out  1  the returned fetch was misaligned or out of range.

Behaviour:
- FSM has two states, LOAD and RUN. Reset enters LOAD.
- Reset values:
  - load_count=0, load_full=0, core_ready=0.
  - fetch_valid=0, fetch_instr=0, fetch_fault=0.
  - Read pipeline stages cleared.
  - Memory array is NOT cleared; contents survive reset.
- LOAD state:
  - load_valid && !load_full: write mem[load_count] <= load_data, then load_count++.
  - load_full = (load_count == DEPTH), registered.
  - load_valid while full: word dropped, count unchanged, no wrap-around.
  - load_done: go to RUN next cycle, and core_ready rises on that same edge.
  - load_valid and load_done in the same cycle: the word is written (if not full), then the FSM moves to RUN.
  - load_done with load_count==0 is legal; unwritten words are read as stored.
  - fetch_req is ignored; no fetch_valid is produced.
- RUN state:
  - load_valid and load_done are ignored; memory is read-only.
  - The only exit is reset, which returns to LOAD.
- Fetch address decode:
  - idx = fetch_addr >> 2.
  - fault = (fetch_addr[1:0] != 0) || (idx >= DEPTH).
  - Upper address bits beyond clog2(DEPTH)+2 are part of the range check; no aliasing.
- Fetch pipeline:
  - A fetch_req accepted at edge N produces fetch_valid=1 at edge N+RD_LAT, for exactly one cycle per request.
  - fault: fetch_instr=NOP_WORD, fetch_fault=1.
  - no fault: fetch_instr=mem[idx], fetch_fault=0.
  - Back-to-back requests every cycle are supported with full throughput; there is no backpressure.
  - When fetch_valid=0, fetch_instr and fetch_fault hold their last values.
- Reset mid-operation:
  - In-flight fetches are discarded; no fetch_valid emerges after reset.
  - The pointer returns to 0, so a subsequent load overwrites from word 0.
- RD_LAT=2 adds one output register after the array read. The fault flag is pipelined alongside the data.

Test Plan:
- Reset, then load 3 words (3c010000, 34240050, 20050004), then load_done. Required: load_count=3, core_ready=1 on the edge after done. Fetches of addr 0, 4, 8 return those words with fetch_valid exactly RD_LAT cycles after each request.
- Load DEPTH+2 words. Required: load_full=1 after word DEPTH, load_count=DEPTH, and the last two words are dropped. Fetch of addr (DEPTH-1)*4 returns word DEPTH-1.
- In RUN, fetch addr 0x06, then addr DEPTH*4. Required: both return fetch_fault=1 and fetch_instr=00000000. Next fetch of addr 0x04 returns 34240050 with fault=0.
- Drive fetch_req every cycle over addrs 0..0x1c with RD_LAT=1 and RD_LAT=2. Required: 8 consecutive fetch_valid pulses, in order, with no bubbles.
- Drive load_valid and load_done in the same cycle with data 0c000018 at count 3. Required: mem[3]=0c000018 and the FSM is in RUN. A load_valid in RUN leaves memory unchanged (fetch of 0x0c still returns 0c000018).
- Assert reset with two fetches in flight. Required: no fetch_valid afterwards and core_ready=0. After reload of one word aaaa5555 plus load_done, fetch 0 returns aaaa5555 and fetch 4 returns the pre-reset 34240050.
